// File: rtl/mips_mmio_uart_port.sv
// mips_mmio_uart_port
//   Memory-mapped peripheral on the MIPS data-memory bus (MEM stage). It provides:
//     - a buffered UART transmitter (TX FIFO feeding a serializer FSM);
//     - a 32-bit output latch driving PortOut;
//     - a synchronized sampler for the asynchronous 8-bit PortIn.
//
//   Register window: 16 bytes at BASE_ADDR. Word offset = Address[3:2].
//     0 TXDATA  (write pushes WriteData[7:0]; reads 0)
//     1 STATUS  {27'b0, busy, overflow, rxNew, empty, full}
//     2 RXDATA  {24'b0, synced PortIn}
//     3 PORTOUT (32-bit read/write latch)
//
//   Optional feature: define MIPS_MMIO_UART_PARITY_EN to add an even-parity bit
//   after the data bits. A frame is then 11 bit times instead of 10.
//
// Ports
//   clk        system clock (rising edge)
//   reset      asynchronous, active-low reset
//   Address    byte address from the ALU
//   WriteData  store data
//   MemWrite   store strobe
//   MemRead    load strobe
//   ReadData   load data (combinational, zero unless a load hits the window)
//   Hit        Address lies inside the window (combinational)
//   PortIn     asynchronous external input
//   PortOut    output latch
//   tx         UART serial line, idle high
module mips_mmio_uart_port #(
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        tx
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef MIPS_MMIO_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } uartState_t;

   // Address decode
   logic       sel;
   logic [1:0] offset;
   logic       unusedAddrBits;

   assign sel            = (Address[31:4] == BASE_ADDR[31:4]);
   assign offset         = Address[3:2];
   assign Hit            = sel;
   assign unusedAddrBits = ^Address[1:0];

   // FIFO storage and occupancy
   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             txWrite;
   logic             push;
   logic             pop;
   logic             overflow;

   // Serializer
   uartState_t        state;
   logic [BAUD_W-1:0] baudCnt;
   logic [2:0]        bitCnt;
   logic [7:0]        shiftReg;
   logic              baudDone;
   logic              busy;
`ifdef MIPS_MMIO_UART_PARITY_EN
   logic              parityBit;
`endif

   // PortIn sampling
   logic [7:0] sync1;
   logic [7:0] sync2;
   logic [7:0] prev;
   logic       rxNew;

   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign txWrite  = sel && MemWrite && (offset == 2'd0);
   assign push     = txWrite && !full;
   assign baudDone = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign busy     = (state != IDLE);
   // Pop happens exactly when the serializer loads a new byte
   assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baudDone));

   // Read mux; side effects of reads are applied in the sequential blocks
   always_comb begin
      ReadData = '0;
      if (sel && MemRead) begin
         case (offset)
            2'd1:    ReadData = {27'b0, busy, overflow, rxNew, empty, full};
            2'd2:    ReadData = {24'b0, sync2};
            2'd3:    ReadData = PortOut;
            default: ReadData = '0;
         endcase
      end
   end

   // FIFO data array (no reset needed; validity tracked by count)
   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr] <= WriteData[7:0];
   end

   // FIFO pointers, count and sticky overflow (set beats the STATUS-read clear)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (txWrite && full)
            overflow <= 1'b1;
         else if (sel && MemRead && (offset == 2'd1))
            overflow <= 1'b0;
      end
   end

   // UART serializer; tx is registered and changes on state-entry edges
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
         tx       <= 1'b1;
`ifdef MIPS_MMIO_UART_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         baudCnt <= baudDone ? '0 : baudCnt + BAUD_W'(1);
         case (state)
            IDLE: begin
               baudCnt <= '0;
               if (pop) begin
                  shiftReg <= fifoMem[rdPtr];
`ifdef MIPS_MMIO_UART_PARITY_EN
                  parityBit <= ^fifoMem[rdPtr];
`endif
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baudDone) begin
                  tx     <= shiftReg[0];
                  bitCnt <= '0;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (baudDone) begin
                  if (bitCnt == 3'd7) begin
`ifdef MIPS_MMIO_UART_PARITY_EN
                     tx    <= parityBit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     tx       <= shiftReg[1];
                     shiftReg <= {1'b0, shiftReg[7:1]};
                     bitCnt   <= bitCnt + 3'd1;
                  end
               end
            end
`ifdef MIPS_MMIO_UART_PARITY_EN
            PARITY: begin
               if (baudDone) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (baudDone) begin
                  // Back-to-back frames: go straight to START with no idle gap
                  if (pop) begin
                     shiftReg <= fifoMem[rdPtr];
`ifdef MIPS_MMIO_UART_PARITY_EN
                     parityBit <= ^fifoMem[rdPtr];
`endif
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   // PortIn synchronizer and change detect (set beats the RXDATA-read clear)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         rxNew <= 1'b0;
      end else begin
         sync1 <= PortIn;
         sync2 <= sync1;
         prev  <= sync2;
         if (sync2 != prev)
            rxNew <= 1'b1;
         else if (sel && MemRead && (offset == 2'd2))
            rxNew <= 1'b0;
      end
   end

   // Output latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         PortOut <= '0;
      else if (sel && MemWrite && (offset == 2'd3))
         PortOut <= WriteData;
   end

endmodule

// File: tb/tb_mips_mmio_uart_port.sv
// Directed testbench for mips_mmio_uart_port (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_mips_mmio_uart_port;

   localparam int unsigned CLKS  = 4;
   localparam int unsigned DEPTH = 8;
`ifdef MIPS_MMIO_UART_PARITY_EN
   localparam int unsigned BITS  = 11;
`else
   localparam int unsigned BITS  = 10;
`endif
   localparam int unsigned FRAME = BITS * CLKS;
   localparam logic [31:0] BASE  = 32'h1001_0040;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic        tx;

   int compared   = 0;
   int mismatched = 0;

   mips_mmio_uart_port #(
      .BASE_ADDR   (BASE),
      .FIFO_DEPTH  (DEPTH),
      .CLKS_PER_BIT(CLKS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Address  (Address),
      .WriteData(WriteData),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .ReadData (ReadData),
      .Hit      (Hit),
      .PortIn   (PortIn),
      .PortOut  (PortOut),
      .tx       (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      Address   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
      Address   = '0;
   endtask

   // Combinational peek without crossing an edge
   task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] expected);
      Address = addr;
      MemRead = 1'b1;
      #1;
      check(tag, ReadData, expected);
   endtask

   task automatic release_bus();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Address  = '0;
   endtask

   // Expected line level for bit time k of a frame carrying d
   function automatic logic expBit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef MIPS_MMIO_UART_PARITY_EN
      if (k == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   initial begin
      reset     = 1'b0;
      Address   = '0;
      WriteData = '0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      PortIn    = 8'h00;

      // Reset state
      tick();
      tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_portout", PortOut, 32'h0);
      check("rst_readdata", ReadData, 32'h0);
      peek("rst_status", BASE + 32'd4, 32'h0000_0002);
      release_bus();
      reset = 1'b1;
      tick();

      // Reset in the middle of a frame
      store(BASE + 32'd12, 32'h1234_5678);
      check("portout_pre", PortOut, 32'h1234_5678);
      store(BASE, 32'h0000_0055);
      tick();
      check("rstf_start", 32'(tx), 32'd0);
      repeat (9) tick();
      check("rstf_data1", 32'(tx), 32'd0);
      reset = 1'b0;
      #1;
      check("rstf_tx", 32'(tx), 32'd1);
      check("rstf_portout", PortOut, 32'h0);
      peek("rstf_status", BASE + 32'd4, 32'h0000_0002);
      release_bus();
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();

      // Single frame 0xA5
      store(BASE, 32'h0000_00A5);
      for (int i = 1; i <= int'(FRAME); i++) begin
         tick();
         check($sformatf("a5_tx_c%0d", i), 32'(tx), 32'(expBit(8'hA5, (i - 1) / int'(CLKS))));
      end
      peek("a5_busy_end", BASE + 32'd4, 32'h0000_0012);
      tick();
      check("a5_idle_status", ReadData, 32'h0000_0002);
      release_bus();

      // Overflow and back-to-back frames
      for (int b = 1; b <= 10; b++) store(BASE, 32'(b));
      peek("ovf_status", BASE + 32'd4, 32'h0000_0019);
      tick();
      check("ovf_cleared", ReadData, 32'h0000_0011);
      release_bus();
      for (int i = 10; i <= 9 * int'(FRAME); i++) begin
         if (i > 10) tick();
         check($sformatf("b2b_tx_c%0d", i), 32'(tx),
               32'(expBit(8'((i - 1) / int'(FRAME) + 1), ((i - 1) % int'(FRAME)) / int'(CLKS))));
      end
      tick();
      check("b2b_tx_idle", 32'(tx), 32'd1);
      peek("b2b_status_done", BASE + 32'd4, 32'h0000_0002);
      release_bus();

      // PORTOUT write and readback; TXDATA reads 0
      store(BASE + 32'd12, 32'hDEAD_BEEF);
      check("portout_write", PortOut, 32'hDEAD_BEEF);
      peek("portout_read", 32'h1001_004C, 32'hDEAD_BEEF);
      check("portout_hit", 32'(Hit), 32'd1);
      peek("txdata_read", BASE, 32'h0);
      release_bus();
      tick();

      // PortIn change detect
      PortIn = 8'h3C;
      tick();
      tick();
      peek("rx_not_yet", BASE + 32'd4, 32'h0000_0002);
      tick();
      check("rx_new_set", ReadData, 32'h0000_0006);
      peek("rx_data", 32'h1001_004B, 32'h0000_003C);
      tick();
      release_bus();
      peek("rx_new_cleared", BASE + 32'd4, 32'h0000_0002);
      release_bus();

      // Decode misses on both sides of the window
      Address   = 32'h1001_0050;
      WriteData = 32'h0000_0099;
      MemWrite  = 1'b1;
      MemRead   = 1'b1;
      #1;
      check("miss_hi_hit", 32'(Hit), 32'd0);
      check("miss_hi_rd", ReadData, 32'h0);
      tick();
      Address = 32'h1001_003C;
      #1;
      check("miss_lo_hit", 32'(Hit), 32'd0);
      check("miss_lo_rd", ReadData, 32'h0);
      tick();
      release_bus();
      check("miss_portout", PortOut, 32'hDEAD_BEEF);
      peek("miss_status", BASE + 32'd4, 32'h0000_0002);
      release_bus();
      tick();
      check("miss_tx", 32'(tx), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mips_mmio_uart_port.md
Name: mips_mmio_uart_port

Overview:
- Memory-mapped I/O peripheral on the MIPS processor's data-memory bus, sitting next to DataMemory in the MEM stage.
- Consumes store/load requests (address, write data, MemWrite, MemRead) that decode into its window and returns read data for writeback.
- Contains a buffered UART transmitter (TX FIFO and serializer FSM), a 32-bit output latch that drives PortOut, and a synchronized sampler for the 8-bit PortIn.

Parameters:
- BASE_ADDR, 32'h1001_0040, byte address of the register window (word aligned; window is 16 bytes).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 434, clock cycles per UART bit; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  byte address from the ALU result.
- WriteData  in  32  store data (rt value).
- MemWrite  in  1  store strobe, one cycle per store.
- MemRead  in  1  load strobe.
- ReadData  out  32  load data; combinational from registers.
- Hit  out  1  high when Address falls inside the window; the top level selects ReadData over DataMemory.
- PortIn  in  8  asynchronous external input.
- PortOut  out  32  output latch.
- tx  out  1  UART serial line, idle high.

Behaviour:
- Decode: sel = (Address[31:4] == BASE_ADDR[31:4]). Offset is Address[3:2]; Address[1:0] is ignored.
- Register map:
  - 0 TXDATA: write pushes WriteData[7:0]; reads 0.
  - 1 STATUS (read-only): bit0 full, bit1 empty, bit2 rx_new, bit3 overflow, bit4 busy, bits[31:5] zero.
  - 2 RXDATA: reads {24'b0, synced PortIn}.
  - 3 PORTOUT: read/write 32-bit latch.
- Reads: ReadData = register value when (sel && MemRead), else 0. Reads with side effects apply them at the clock edge where sel && MemRead is high.
- Reset (async, immediate, also mid-frame):
  - tx=1, PortOut=0, ReadData=0.
  - FIFO empty (count=0, pointers 0), overflow=0, rx_new=0.
  - Synchronizer flops 0, FSM in IDLE, bit counter and baud counter 0.
- FIFO:
  - Push on sel && MemWrite && offset 0 && !full. A push while full is dropped and sets overflow (sticky).
  - Pop occurs only when the FSM leaves IDLE, or leaves STOP with the FIFO non-empty.
  - Simultaneous push and pop leaves count unchanged and both take effect.
  - Pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH); empty = (count == 0).
- STATUS read clears overflow at that edge. If an overflow occurs on the same edge, the set wins.
- PortIn path:
  - Two-flop synchronizer, then a registered copy prev.
  - rx_new sets when the synced value != prev.
  - RXDATA read clears rx_new. A set wins over a clear on the same edge.
- TX FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: if !empty, load the head byte into the shift register, pop, go to START. tx goes low on that edge. Minimum latency is a push at edge N, tx low after edge N+1.
  - Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, counted by a baud counter that restarts on every state entry.
  - START: tx=0. DATA: 8 bits, LSB first. STOP: tx=1.
  - At the end of STOP: if !empty, go straight to START (load and pop); else go to IDLE. There are no idle cycles between back-to-back frames.
  - busy = (state != IDLE).
- PORTOUT write updates PortOut on the next edge.
- Accesses outside the window have no effect, and Hit=0.

Optional Feature:
- Macro: MIPS_MMIO_UART_PARITY_EN.
- Defined: the PARITY state follows DATA, driving the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. A frame is 11 bit times.
- Undefined: there is no PARITY state, DATA goes directly to STOP, and a frame is 10 bit times.

Test Plan:
- Reset during a frame: with CLKS_PER_BIT=4, write 0x55 to BASE_ADDR; assert reset in mid-DATA -> tx=1 immediately, STATUS reads 0x02, PortOut=0.
- Single frame: with CLKS_PER_BIT=4, store 0x000000A5 to 0x10010040 -> tx low 1 cycle after the store edge, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop high. busy=0 after 40 cycles (44 with parity, parity bit 0).
- Overflow and back-to-back: with FIFO_DEPTH=8, issue 10 consecutive stores of 0x01..0x0A -> 9 bytes transmitted (0x01..0x09, the first pops immediately), 0x0A is dropped. STATUS bit3=1; a second STATUS read shows bit3=0. Stop-to-start gap is 0 cycles.
- PortOut: store 0xDEADBEEF to 0x1001004C -> PortOut=0xDEADBEEF next edge; a load from 0x1001004C returns 0xDEADBEEF with Hit=1.
- PortIn: change PortIn from 0x00 to 0x3C -> STATUS bit2=1 three edges later; load 0x10010048 returns 0x3C and clears bit2.
- Decode miss: store to 0x10010050 or 0x1001003C -> Hit=0, no state change, ReadData=0.
